// File: rtl/rgb_out_pack_if.sv
// Stream bundle for rgb_out_pack: LAB-side credit handshake with converter
// results, and the packed RGB valid/ready output stream.
interface rgb_out_pack_if #(
    parameter int DSIZE = 16
);
    logic             lab_valid;
    logic             lab_ready;
    logic [DSIZE-1:0] R;
    logic [DSIZE-1:0] G;
    logic [DSIZE-1:0] B;
    logic             sign_r;
    logic             sign_g;
    logic             sign_b;
    logic             rgb_valid;
    logic             rgb_ready;
    logic [23:0]      rgb_data;

    modport master (
        output lab_valid, R, G, B, sign_r, sign_g, sign_b, rgb_ready,
        input  lab_ready, rgb_valid, rgb_data
    );

    modport slave (
        input  lab_valid, R, G, B, sign_r, sign_g, sign_b, rgb_ready,
        output lab_ready, rgb_valid, rgb_data
    );
endinterface

// File: rtl/rgb_out_pack.sv
// Output stage behind the LAB-to-RGB converter: tracks accepted pixels through the
// fixed-latency pipe, rounds/saturates to 8 bits, and buffers them in a credit-guarded FIFO.
module rgb_out_pack #(
    parameter int DSIZE = 16,
    parameter int FRAC  = 8,
    parameter int LAT   = 12,
    parameter int DEPTH = 16
) (
    input  logic          clock,
    input  logic          rst_n,
    rgb_out_pack_if.slave bus,
    output logic [15:0]   clip_cnt
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]  DEPTH_C  = CW'(DEPTH);
    localparam logic [PW-1:0]  LAST_PTR = PW'(DEPTH - 1);
    localparam logic [DSIZE:0] HALF     = (DSIZE + 1)'(1) << (FRAC - 1);
    localparam logic [DSIZE:0] MAX8     = (DSIZE + 1)'(255);

    logic [LAT-1:0]   tag_q, tag_d;
    logic [CW-1:0]    occ_q, occ_d;
    logic [CW-1:0]    fill_q, fill_d;
    logic [PW-1:0]    wrPtr_q, wrPtr_d;
    logic [PW-1:0]    rdPtr_q, rdPtr_d;
    logic [15:0]      clipCnt_q, clipCnt_d;
    logic [23:0]      mem_q [DEPTH];

    logic             acc;
    logic             pop;
    logic             wrEn;
    logic [23:0]      wrWord;
    logic             anyClip;
    logic [DSIZE-1:0] mag     [3];
    logic [2:0]       sgn;
    logic [DSIZE:0]   rounded [3];
    logic [7:0]       chan8   [3];
    logic [2:0]       clip;

    assign bus.lab_ready = (occ_q < DEPTH_C);
    assign bus.rgb_valid = (fill_q != '0);
    assign bus.rgb_data  = bus.rgb_valid ? mem_q[rdPtr_q] : 24'h0;
    assign clip_cnt      = clipCnt_q;

    // Rounding is done one bit wider than the input so value + half never loses its carry.
    always_comb begin
        mag[0] = bus.R;
        mag[1] = bus.G;
        mag[2] = bus.B;
        sgn[0] = bus.sign_r;
        sgn[1] = bus.sign_g;
        sgn[2] = bus.sign_b;
        clip   = '0;
        for (int c = 0; c < 3; c++) begin
            rounded[c] = ({1'b0, mag[c]} + HALF) >> FRAC;
            chan8[c]   = 8'h00;
            if (sgn[c]) begin
                clip[c] = |mag[c];
            end else if (rounded[c] > MAX8) begin
                chan8[c] = 8'hFF;
                clip[c]  = 1'b1;
            end else begin
                chan8[c] = 8'(rounded[c]);
            end
        end
        wrWord  = {chan8[0], chan8[1], chan8[2]};
        anyClip = |clip;
    end

    always_comb begin
        acc       = bus.lab_valid && bus.lab_ready;
        pop       = bus.rgb_valid && bus.rgb_ready;
        wrEn      = tag_q[LAT-1];
        tag_d     = LAT'({tag_q, acc});
        occ_d     = occ_q;
        fill_d    = fill_q;
        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        clipCnt_d = clipCnt_q;

        if (acc && !pop) begin
            occ_d = occ_q + CW'(1);
        end else if (!acc && pop) begin
            occ_d = occ_q - CW'(1);
        end

        if (wrEn && !pop) begin
            fill_d = fill_q + CW'(1);
        end else if (!wrEn && pop) begin
            fill_d = fill_q - CW'(1);
        end

        if (wrEn) begin
            wrPtr_d = (wrPtr_q == LAST_PTR) ? '0 : wrPtr_q + PW'(1);
            if (anyClip && clipCnt_q != 16'hFFFF) begin
                clipCnt_d = clipCnt_q + 16'd1;
            end
        end
        if (pop) begin
            rdPtr_d = (rdPtr_q == LAST_PTR) ? '0 : rdPtr_q + PW'(1);
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            tag_q     <= '0;
            occ_q     <= '0;
            fill_q    <= '0;
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            clipCnt_q <= '0;
        end else begin
            tag_q     <= tag_d;
            occ_q     <= occ_d;
            fill_q    <= fill_d;
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            clipCnt_q <= clipCnt_d;
        end
    end

    // Pixel storage needs no reset: the fill count alone decides what is visible.
    always_ff @(posedge clock) begin
        if (wrEn) begin
            mem_q[wrPtr_q] <= wrWord;
        end
    end

    noOverflow: assert property (@(posedge clock) disable iff (!rst_n)
        !(wrEn && (fill_q == DEPTH_C) && !pop));
endmodule

// File: tb/tb_rgb_out_pack.sv
// Randomised bench for rgb_out_pack: emulates the converter delay line and checks every
// cycle against a queue-based model of tracked pixels, FIFO contents and credits.
module tb_rgb_out_pack;
    localparam int DSIZE = 16;
    localparam int FRAC  = 8;
    localparam int LAT   = 12;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic        sr;
        logic        sg;
        logic        sb;
        logic [15:0] r;
        logic [15:0] g;
        logic [15:0] b;
    } pix_t;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] clipCnt;

    rgb_out_pack_if #(.DSIZE(DSIZE)) bus ();

    rgb_out_pack #(
        .DSIZE(DSIZE),
        .FRAC (FRAC),
        .LAT  (LAT),
        .DEPTH(DEPTH)
    ) dut (
        .clock   (clock),
        .rst_n   (rst_n),
        .bus     (bus),
        .clip_cnt(clipCnt)
    );

    always #5 clock = ~clock;

    int   total = 0;
    int   bad   = 0;
    int   dutAccepts = 0;
    pix_t convPipe [LAT];
    pix_t labPayload;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [15:0] randMag();
        case ($urandom_range(7))
            0:       return 16'hFF80 + 16'($urandom_range(127));
            1:       return 16'hFF7F;
            2:       return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic pix_t randPix();
        pix_t p;
        p.sr = ($urandom_range(3) == 0);
        p.sg = ($urandom_range(3) == 0);
        p.sb = ($urandom_range(3) == 0);
        p.r  = randMag();
        p.g  = randMag();
        p.b  = randMag();
        return p;
    endfunction

    // Returns {anyClip, R8, G8, B8} from plain integer rounding and saturation.
    function automatic logic [24:0] modelPixel(input pix_t p);
        int          mags [3];
        logic        sgns [3];
        int          out8;
        logic        anyClip = 1'b0;
        logic [23:0] w = 24'h0;
        mags[0] = int'(p.r); mags[1] = int'(p.g); mags[2] = int'(p.b);
        sgns[0] = p.sr;      sgns[1] = p.sg;      sgns[2] = p.sb;
        for (int c = 0; c < 3; c++) begin
            if (sgns[c]) begin
                out8 = 0;
                if (mags[c] != 0) anyClip = 1'b1;
            end else begin
                out8 = (mags[c] + (1 << (FRAC - 1))) / (1 << FRAC);
                if (out8 > 255) begin
                    out8    = 255;
                    anyClip = 1'b1;
                end
            end
            w = {w[15:0], 8'(out8)};
        end
        return {anyClip, w};
    endfunction

    // One cycle of stimulus at the falling edge; the converter pipe shifts the payload
    // that was on the LAB side during the cycle just sampled.
    task automatic applyStimulus(input logic valid, input logic rdy, input pix_t pix);
        @(negedge clock);
        for (int k = LAT - 1; k > 0; k--) convPipe[k] = convPipe[k-1];
        convPipe[0]   = labPayload;
        labPayload    = pix;
        bus.lab_valid = valid;
        bus.rgb_ready = rdy;
        bus.R         = convPipe[LAT-1].r;
        bus.G         = convPipe[LAT-1].g;
        bus.B         = convPipe[LAT-1].b;
        bus.sign_r    = convPipe[LAT-1].sr;
        bus.sign_g    = convPipe[LAT-1].sg;
        bus.sign_b    = convPipe[LAT-1].sb;
        if (valid && bus.lab_ready) dutAccepts++;
    endtask

    int          tagQ  [$];
    logic [23:0] fifoQ [$];
    int          mOcc    = 0;
    int          mClips  = 0;
    int          edgeNum = 0;

    always @(posedge clock) begin : modelAndCompare
        logic        mAcc;
        logic        mPop;
        logic        mWr;
        logic [24:0] res;
        pix_t        seen;
        if (!rst_n) begin
            tagQ.delete();
            fifoQ.delete();
            mOcc   = 0;
            mClips = 0;
        end else begin
            seen = '{sr: bus.sign_r, sg: bus.sign_g, sb: bus.sign_b, r: bus.R, g: bus.G, b: bus.B};
            mAcc = bus.lab_valid && (mOcc < DEPTH);
            mPop = (fifoQ.size() > 0) && bus.rgb_ready;
            mWr  = (tagQ.size() > 0) && (tagQ[0] == edgeNum - LAT);
            res  = modelPixel(seen);
            if (mWr) void'(tagQ.pop_front());
            if (mPop) void'(fifoQ.pop_front());
            if (mWr) begin
                fifoQ.push_back(res[23:0]);
                if (res[24] && mClips < 65535) mClips++;
            end
            if (mAcc) tagQ.push_back(edgeNum);
            mOcc = mOcc + int'(mAcc) - int'(mPop);
        end
        edgeNum++;
        #1;
        checkOutput("rgb_valid", 32'(bus.rgb_valid), 32'(fifoQ.size() > 0));
        checkOutput("rgb_data", 32'(bus.rgb_data), (fifoQ.size() > 0) ? 32'(fifoQ[0]) : 32'h0);
        checkOutput("lab_ready", 32'(bus.lab_ready), 32'(mOcc < DEPTH));
        checkOutput("clip_cnt", 32'(clipCnt), 32'(mClips));
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        pix_t p;
        int   cyc;
        for (int k = 0; k < LAT; k++) convPipe[k] = randPix();
        labPayload    = randPix();
        bus.lab_valid = 1'b0;
        bus.rgb_ready = 1'b0;
        bus.R         = convPipe[LAT-1].r;
        bus.G         = convPipe[LAT-1].g;
        bus.B         = convPipe[LAT-1].b;
        bus.sign_r    = convPipe[LAT-1].sr;
        bus.sign_g    = convPipe[LAT-1].sg;
        bus.sign_b    = convPipe[LAT-1].sb;

        repeat (3) applyStimulus(1'b0, 1'b0, randPix());
        rst_n = 1'b1;
        $display("[TB] reset released, idle with random converter outputs");
        repeat (50) applyStimulus(1'b0, 1'b0, randPix());
        checkOutput("idle_valid", 32'(bus.rgb_valid), 32'h0);
        checkOutput("idle_data", 32'(bus.rgb_data), 32'h0);
        checkOutput("idle_ready", 32'(bus.lab_ready), 32'h1);

        p = '{sr: 1'b0, sg: 1'b0, sb: 1'b1, r: 16'h1280, g: 16'hFF7F, b: 16'h0100};
        applyStimulus(1'b1, 1'b0, p);
        repeat (LAT + 1) applyStimulus(1'b0, 1'b0, randPix());
        checkOutput("single_valid", 32'(bus.rgb_valid), 32'h1);
        checkOutput("single_data", 32'(bus.rgb_data), 32'h13FF00);
        checkOutput("single_clip", 32'(clipCnt), 32'h1);
        repeat (2) applyStimulus(1'b0, 1'b1, randPix());

        p = '{sr: 1'b0, sg: 1'b0, sb: 1'b0, r: 16'hFF80, g: 16'h0000, b: 16'h0000};
        applyStimulus(1'b1, 1'b0, p);
        p = '{sr: 1'b1, sg: 1'b0, sb: 1'b0, r: 16'h0000, g: 16'h0080, b: 16'h017F};
        applyStimulus(1'b1, 1'b0, p);
        repeat (LAT + 1) applyStimulus(1'b0, 1'b0, randPix());
        checkOutput("round_ovf_data", 32'(bus.rgb_data), 32'hFF0000);
        checkOutput("round_ovf_clip", 32'(clipCnt), 32'h2);
        applyStimulus(1'b0, 1'b1, randPix());
        applyStimulus(1'b0, 1'b0, randPix());
        checkOutput("neg_zero_data", 32'(bus.rgb_data), 32'h000101);
        checkOutput("neg_zero_clip", 32'(clipCnt), 32'h2);
        repeat (3) applyStimulus(1'b0, 1'b1, randPix());

        $display("[TB] filling with sink stalled");
        dutAccepts = 0;
        repeat (LAT + DEPTH + 4) applyStimulus(1'b1, 1'b0, randPix());
        checkOutput("fill_accepts", 32'(dutAccepts), 32'd16);
        checkOutput("fill_ready", 32'(bus.lab_ready), 32'h0);
        checkOutput("fill_valid", 32'(bus.rgb_valid), 32'h1);
        applyStimulus(1'b0, 1'b1, randPix());
        applyStimulus(1'b0, 1'b0, randPix());
        checkOutput("pop_ready", 32'(bus.lab_ready), 32'h1);
        dutAccepts = 0;
        applyStimulus(1'b1, 1'b0, randPix());
        applyStimulus(1'b0, 1'b0, randPix());
        checkOutput("refill_accepts", 32'(dutAccepts), 32'd1);
        checkOutput("refill_ready", 32'(bus.lab_ready), 32'h0);
        repeat (LAT + 2 * DEPTH) applyStimulus(1'b0, 1'b1, randPix());

        $display("[TB] random traffic");
        dutAccepts = 0;
        cyc        = 0;
        while (dutAccepts < 1000 && cyc < 20000) begin
            applyStimulus($urandom_range(9) < 7, $urandom_range(9) < 6, randPix());
            cyc++;
        end
        checkOutput("random_accepts", 32'(dutAccepts), 32'd1000);
        repeat (LAT + 2 * DEPTH) applyStimulus(1'b0, 1'b1, randPix());
        checkOutput("drain_valid", 32'(bus.rgb_valid), 32'h0);
        checkOutput("drain_ready", 32'(bus.lab_ready), 32'h1);

        $display("[TB] reset with pixels in flight");
        repeat (5) applyStimulus(1'b1, 1'b0, randPix());
        repeat (3) applyStimulus(1'b0, 1'b0, randPix());
        applyStimulus(1'b0, 1'b0, randPix());
        rst_n = 1'b0;
        repeat (3) applyStimulus(1'b0, 1'b1, randPix());
        rst_n = 1'b1;
        repeat (LAT + 5) applyStimulus(1'b0, 1'b1, randPix());
        checkOutput("post_reset_valid", 32'(bus.rgb_valid), 32'h0);
        checkOutput("post_reset_data", 32'(bus.rgb_data), 32'h0);
        checkOutput("post_reset_clip", 32'(clipCnt), 32'h0);
        checkOutput("post_reset_ready", 32'(bus.lab_ready), 32'h1);

        repeat (2) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
